// File: rtl/zion_basic_circuit_lib_clr_rsn_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zion_basic_circuit_lib_clr_rsn_pipe_pkg                                  |
// | Shared helpers and macros for the clear/reset handshaked pipeline.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`ifndef ZION_BASIC_CIRCUIT_LIB_CLR_RSN_PIPE_PKG_MACROS
`define ZION_BASIC_CIRCUIT_LIB_CLR_RSN_PIPE_PKG_MACROS

`ifdef CHECK_ERR_EXIT
`define ZION_CLR_RSN_PIPE_PARAM_ERR(msg_) $fatal(1, msg_);
`else
`define ZION_CLR_RSN_PIPE_PARAM_ERR(msg_) $error(msg_);
`endif

`define ZION_BASIC_CIRCUIT_LIB_CLR_RSN_PIPE(uname_, depth_, clk_, rst_, clr_, ivld_, ordy_, idat_, ovld_, irdy_, odat_, ocnt_) \
    initial begin \
        if ($bits(idat_) != $bits(odat_)) begin \
            `ZION_CLR_RSN_PIPE_PARAM_ERR("clr_rsn_pipe: iDat/oDat width mismatch") \
        end \
    end \
    zion_basic_circuit_lib_clr_rsn_pipe #( \
        .WIDTH ($bits(idat_)), \
        .DEPTH (depth_) \
    ) uname_ ( \
        .clk  (clk_), \
        .rst  (rst_), \
        .iClr (clr_), \
        .iVld (ivld_), \
        .oRdy (ordy_), \
        .iDat (idat_), \
        .oVld (ovld_), \
        .iRdy (irdy_), \
        .oDat (odat_), \
        .oCnt (ocnt_) \
    );

`endif

package zion_basic_circuit_lib_clr_rsn_pipe_pkg;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/zion_basic_circuit_lib_clr_rsn_pipe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zion_basic_circuit_lib_clr_rsn_pipe_stage                                |
// | One valid/data register pair with load enable, flush and init value.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module zion_basic_circuit_lib_clr_rsn_pipe_stage #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;

    // Data only captures real beats so bubbles do not toggle the register.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (clr_i) begin
            vld_d = 1'b0;
            dat_d = INI_DATA;
        end else if (ld_i) begin
            vld_d = vld_i;
            if (vld_i) begin
                dat_d = dat_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= 1'b0;
            dat_q <= INI_DATA;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule
`default_nettype wire

// File: rtl/zion_basic_circuit_lib_clr_rsn_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zion_basic_circuit_lib_clr_rsn_pipe                                      |
// | DEPTH-stage valid/ready pipeline with bubble collapse and sync flush.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module zion_basic_circuit_lib_clr_rsn_pipe
    import zion_basic_circuit_lib_clr_rsn_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] INI_DATA  = '0,
    parameter int               CNT_WIDTH = clog2_f(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iClr,
    input  logic                 iVld,
    output logic                 oRdy,
    input  logic [WIDTH-1:0]     iDat,
    output logic                 oVld,
    input  logic                 iRdy,
    output logic [WIDTH-1:0]     oDat,
    output logic [CNT_WIDTH-1:0] oCnt
);

    if ((DEPTH < 1) || ($bits(INI_DATA) > WIDTH)) begin : g_param_err
        `ZION_CLR_RSN_PIPE_PARAM_ERR("clr_rsn_pipe: illegal DEPTH or INI_DATA width")
    end

    logic [DEPTH-1:0] rdy_w;
    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] dat_q [DEPTH];
    logic             in_fire_w;
    logic             out_fire_w;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    genvar k;
    for (k = 0; k < DEPTH; k++) begin : g_stage
        logic             vld_in_w;
        logic [WIDTH-1:0] dat_in_w;

        // Unrolled ready chain: a stage can load when the sink is ready or any
        // stage from here to the output is empty.
        assign rdy_w[k] = iRdy | ~(&vld_q[DEPTH-1:k]);

        if (k == 0) begin : g_head
            assign vld_in_w = iVld;
            assign dat_in_w = iDat;
        end else begin : g_body
            assign vld_in_w = vld_q[k-1];
            assign dat_in_w = dat_q[k-1];
        end

        zion_basic_circuit_lib_clr_rsn_pipe_stage #(
            .WIDTH    (WIDTH),
            .INI_DATA (INI_DATA)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .clr_i (iClr),
            .ld_i  (rdy_w[k]),
            .vld_i (vld_in_w),
            .dat_i (dat_in_w),
            .vld_o (vld_q[k]),
            .dat_o (dat_q[k])
        );
    end

    assign oRdy       = rdy_w[0] & ~iClr;
    assign oVld       = vld_q[DEPTH-1] & ~iClr;
    assign oDat       = dat_q[DEPTH-1];
    assign in_fire_w  = iVld & oRdy;
    assign out_fire_w = oVld & iRdy;

    always_comb begin
        cnt_d = cnt_q;
        if (in_fire_w && !out_fire_w) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else if (!in_fire_w && out_fire_w) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || iClr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oCnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_zion_basic_circuit_lib_clr_rsn_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_zion_basic_circuit_lib_clr_rsn_pipe                                   |
// | Directed plus random stimulus against a slot-occupancy reference model.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_zion_basic_circuit_lib_clr_rsn_pipe;

    localparam int               W   = 8;
    localparam int               D   = 3;
    localparam logic [W-1:0]     INI = 8'hA5;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, iClr, iVld, iRdy;
    logic [W-1:0] iDat;
    logic         oRdy, oVld;
    logic [W-1:0] oDat;
    logic [1:0]   oCnt;

    logic         r1_rst, r1_clr, r1_vld, r1_rdy;
    logic [W-1:0] r1_dat;
    logic         o1_rdy, o1_vld;
    logic [W-1:0] o1_dat;
    logic [0:0]   o1_cnt;

    zion_basic_circuit_lib_clr_rsn_pipe #(.WIDTH(W), .DEPTH(D), .INI_DATA(INI)) dut (
        .clk(clk), .rst(rst), .iClr(iClr), .iVld(iVld), .oRdy(oRdy), .iDat(iDat),
        .oVld(oVld), .iRdy(iRdy), .oDat(oDat), .oCnt(oCnt)
    );

    zion_basic_circuit_lib_clr_rsn_pipe #(.WIDTH(W), .DEPTH(1), .INI_DATA(INI)) dut1 (
        .clk(clk), .rst(r1_rst), .iClr(r1_clr), .iVld(r1_vld), .oRdy(o1_rdy), .iDat(r1_dat),
        .oVld(o1_vld), .iRdy(r1_rdy), .oDat(o1_dat), .oCnt(o1_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference: which slots hold a beat, their data, and the delivery history.
    bit           mocc [D];
    logic [W-1:0] mdat [D];
    logic [W-1:0] last_out;
    logic [W-1:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit free_from(input int k);
        for (int j = k; j < D; j++) if (!mocc[j]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int mcount();
        int n = 0;
        for (int j = 0; j < D; j++) n += int'(mocc[j]);
        return n;
    endfunction

    // Called at a negedge: drive, check outputs, advance one clock, update model.
    task automatic step(input bit v, input logic [W-1:0] d, input bit r, input bit c, input bit rs);
        bit           e_rdy, e_vld, in_f, out_f;
        logic [W-1:0] e_dat;
        bit           nocc [D];
        logic [W-1:0] ndat [D];
        iVld = v; iDat = d; iRdy = r; iClr = c; rst = rs;
        #1;
        e_rdy = !c && (r || free_from(0));
        e_vld = mocc[D-1] && !c;
        e_dat = mocc[D-1] ? mdat[D-1] : last_out;
        chk("oRdy", 32'(oRdy), 32'(e_rdy));
        chk("oVld", 32'(oVld), 32'(e_vld));
        chk("oDat", 32'(oDat), 32'(e_dat));
        chk("oCnt", 32'(oCnt), 32'(mcount()));
        in_f  = rs && v && e_rdy;
        out_f = rs && e_vld && r;
        if (out_f) begin
            if (sb.size() == 0) chk("order_empty", 32'(oDat), 32'hFFFF_FFFF);
            else chk("order", 32'(oDat), 32'(sb.pop_front()));
        end
        if (in_f) sb.push_back(d);
        @(posedge clk);
        if (!rs || c) begin
            for (int j = 0; j < D; j++) begin mocc[j] = 1'b0; mdat[j] = INI; end
            last_out = INI;
            sb.delete();
        end else begin
            for (int j = 0; j < D; j++) begin nocc[j] = 1'b0; ndat[j] = mdat[j]; end
            if (mocc[D-1]) begin
                if (r) last_out = mdat[D-1];
                else   nocc[D-1] = 1'b1;
            end
            for (int j = D - 2; j >= 0; j--) begin
                if (mocc[j]) begin
                    if (r || free_from(j + 1)) begin nocc[j+1] = 1'b1; ndat[j+1] = mdat[j]; end
                    else nocc[j] = 1'b1;
                end
            end
            if (v && (r || free_from(0))) begin nocc[0] = 1'b1; ndat[0] = d; end
            for (int j = 0; j < D; j++) begin mocc[j] = nocc[j]; mdat[j] = ndat[j]; end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; iClr = 1'b0; iVld = 1'b0; iRdy = 1'b1; iDat = '0;
        r1_rst = 1'b0; r1_clr = 1'b0; r1_vld = 1'b0; r1_rdy = 1'b1; r1_dat = '0;
        for (int j = 0; j < D; j++) begin mocc[j] = 1'b0; mdat[j] = INI; end
        last_out = INI;
        @(negedge clk);
        @(negedge clk);

        // Reset held two cycles, then idle.
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        chk("rst_odat", 32'(oDat), 32'h0000_00A5);
        chk("rst_ocnt", 32'(oCnt), 32'h0);
        step(0, 8'h00, 1, 0, 1);

        // Streaming 01..04 at full throughput.
        step(1, 8'h01, 1, 0, 1);
        step(1, 8'h02, 1, 0, 1);
        step(1, 8'h03, 1, 0, 1);
        chk("stream_latency_vld", 32'(oVld), 32'h1);
        chk("stream_first_dat", 32'(oDat), 32'h01);
        step(1, 8'h04, 1, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 1);

        // Backpressure: three accepted, fourth stalls, then drained.
        step(1, 8'h10, 0, 0, 1);
        step(1, 8'h11, 0, 0, 1);
        step(1, 8'h12, 0, 0, 1);
        chk("bp_full_cnt", 32'(oCnt), 32'h3);
        step(1, 8'h13, 0, 0, 1);
        step(1, 8'h13, 1, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 1);

        // Bubble collapse under backpressure.
        step(1, 8'h20, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'h21, 0, 0, 1);
        chk("bubble_cnt", 32'(oCnt), 32'h2);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 1);

        // Clear with three beats in flight.
        step(1, 8'h30, 0, 0, 1);
        step(1, 8'h31, 0, 0, 1);
        step(1, 8'h32, 0, 0, 1);
        step(1, 8'h33, 1, 1, 1);
        chk("clr_cnt", 32'(oCnt), 32'h0);
        chk("clr_odat", 32'(oDat), 32'h0000_00A5);
        step(0, 8'h00, 1, 0, 1);

        // Random traffic with occasional clear and mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 3) != 0), W'($urandom), bit'($urandom_range(0, 2) != 0),
                 bit'($urandom_range(0, 24) == 0), bit'($urandom_range(0, 49) != 0));
        end

        // Single-stage instance: fill, combinational ready, then rst with clear.
        r1_rst = 1'b1; r1_vld = 1'b1; r1_dat = 8'h5A; r1_rdy = 1'b0;
        #1;
        chk("d1_rdy_empty", 32'(o1_rdy), 32'h1);
        @(negedge clk);
        #1;
        chk("d1_vld_full", 32'(o1_vld), 32'h1);
        chk("d1_dat", 32'(o1_dat), 32'h5A);
        chk("d1_cnt_full", 32'(o1_cnt), 32'h1);
        chk("d1_rdy_full", 32'(o1_rdy), 32'h0);
        r1_rdy = 1'b1;
        #1;
        chk("d1_rdy_passthru", 32'(o1_rdy), 32'h1);
        r1_rst = 1'b0; r1_clr = 1'b1;
        #1;
        chk("d1_clr_rdy", 32'(o1_rdy), 32'h0);
        chk("d1_clr_vld", 32'(o1_vld), 32'h0);
        @(negedge clk);
        r1_rst = 1'b1; r1_clr = 1'b0; r1_vld = 1'b0;
        #1;
        chk("d1_rst_vld", 32'(o1_vld), 32'h0);
        chk("d1_rst_dat", 32'(o1_dat), 32'h0000_00A5);
        chk("d1_rst_cnt", 32'(o1_cnt), 32'h0);
        chk("d1_rst_rdy", 32'(o1_rdy), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
